// File: rtl/fp_addsub_seq.sv
// Multi-cycle add/sub core: aligns the smaller operand, adds or subtracts the
// magnitudes, then normalizes at most NORM_STEP bits per cycle.
module fp_addsub_seq #(
    parameter int NORM_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op_sub,
    input  logic        a_sign,
    input  logic [7:0]  a_exp,
    input  logic [27:0] a_mantis,
    input  logic        b_sign,
    input  logic [7:0]  b_exp,
    input  logic [27:0] b_mantis,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        res_sign,
    output logic [7:0]  res_exp,
    output logic [27:0] res_mantis,
    output logic        res_zero,
    output logic        res_ovf,
    output logic        res_uflow
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    localparam logic [4:0] STEP = 5'(NORM_STEP);

    state_t      state_q, state_d;
    logic        eff_sub_q, eff_sub_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  diff_q, diff_d;
    logic [27:0] m_big_q, m_big_d;
    logic [27:0] m_small_q, m_small_d;
    logic [27:0] sum_q, sum_d;
    logic        res_sign_q, res_sign_d;
    logic [7:0]  res_exp_q, res_exp_d;
    logic [27:0] res_mantis_q, res_mantis_d;
    logic        res_zero_q, res_zero_d;
    logic        res_ovf_q, res_ovf_d;
    logic        res_uflow_q, res_uflow_d;

    logic        a_big;
    logic        norm_done;
    logic [4:0]  lz;
    logic [4:0]  shamt;
    logic [8:0]  exp_inc;
    logic [27:0] sum_shl;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            eff_sub_q    <= 1'b0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            diff_q       <= '0;
            m_big_q      <= '0;
            m_small_q    <= '0;
            sum_q        <= '0;
            res_sign_q   <= 1'b0;
            res_exp_q    <= '0;
            res_mantis_q <= '0;
            res_zero_q   <= 1'b0;
            res_ovf_q    <= 1'b0;
            res_uflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            eff_sub_q    <= eff_sub_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            diff_q       <= diff_d;
            m_big_q      <= m_big_d;
            m_small_q    <= m_small_d;
            sum_q        <= sum_d;
            res_sign_q   <= res_sign_d;
            res_exp_q    <= res_exp_d;
            res_mantis_q <= res_mantis_d;
            res_zero_q   <= res_zero_d;
            res_ovf_q    <= res_ovf_d;
            res_uflow_q  <= res_uflow_d;
        end
    end

    // Leading zeros counted from bit 26 downward; only meaningful when sum_q[27:26]==0
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum_q[i]) lz = 5'(26 - i);
        end
        shamt   = (lz < STEP) ? lz : STEP;
        exp_inc = {1'b0, exp_q} + 9'd1;
        sum_shl = sum_q << shamt;
    end

    assign a_big = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mantis >= b_mantis));

    // Datapath
    always_comb begin
        eff_sub_d    = eff_sub_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        diff_d       = diff_q;
        m_big_d      = m_big_q;
        m_small_d    = m_small_q;
        sum_d        = sum_q;
        res_sign_d   = res_sign_q;
        res_exp_d    = res_exp_q;
        res_mantis_d = res_mantis_q;
        res_zero_d   = res_zero_q;
        res_ovf_d    = res_ovf_q;
        res_uflow_d  = res_uflow_q;
        norm_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    eff_sub_d = a_sign ^ b_sign ^ op_sub;
                    sign_d    = a_big ? a_sign : (b_sign ^ op_sub);
                    exp_d     = a_big ? a_exp : b_exp;
                    diff_d    = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
                    m_big_d   = a_big ? a_mantis : b_mantis;
                    m_small_d = a_big ? b_mantis : a_mantis;
                end
            end
            S_ALIGN: begin
                m_small_d = (diff_q >= 8'd28) ? 28'd0 : (m_small_q >> diff_q);
            end
            S_ADD: begin
                sum_d = eff_sub_q ? (m_big_q - m_small_q) : (m_big_q + m_small_q);
            end
            S_NORM: begin
                res_zero_d  = 1'b0;
                res_ovf_d   = 1'b0;
                res_uflow_d = 1'b0;
                res_sign_d  = sign_q;
                if (sum_q == 28'd0) begin
                    norm_done    = 1'b1;
                    res_zero_d   = 1'b1;
                    res_sign_d   = 1'b0;
                    res_exp_d    = 8'd0;
                    res_mantis_d = 28'd0;
                end else if (sum_q[27]) begin
                    norm_done = 1'b1;
                    if (exp_inc >= 9'd255) begin
                        res_ovf_d    = 1'b1;
                        res_exp_d    = 8'd255;
                        res_mantis_d = 28'd0;
                    end else begin
                        res_exp_d    = exp_inc[7:0];
                        res_mantis_d = sum_q >> 1;
                    end
                end else if (sum_q[26]) begin
                    norm_done    = 1'b1;
                    res_exp_d    = exp_q;
                    res_mantis_d = sum_q;
                end else if (exp_q <= {3'b000, shamt}) begin
                    norm_done    = 1'b1;
                    res_uflow_d  = 1'b1;
                    res_exp_d    = 8'd0;
                    res_mantis_d = 28'd0;
                end else begin
                    sum_d        = sum_shl;
                    exp_d        = exp_q - {3'b000, shamt};
                    norm_done    = (shamt == lz);
                    res_exp_d    = exp_d;
                    res_mantis_d = sum_shl;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    res_zero_d  = 1'b0;
                    res_ovf_d   = 1'b0;
                    res_uflow_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  if (norm_done) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        res_sign   = res_sign_q;
        res_exp    = res_exp_q;
        res_mantis = res_mantis_q;
        res_zero   = res_zero_q;
        res_ovf    = res_ovf_q;
        res_uflow  = res_uflow_q;
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: table of hand-computed vectors plus
// sequences for output backpressure and reset during normalization.
module tb_fp_addsub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic        a_sign;
    logic [7:0]  a_exp;
    logic [27:0] a_mantis;
    logic        b_sign;
    logic [7:0]  b_exp;
    logic [27:0] b_mantis;
    logic        out_valid;
    logic        out_ready;
    logic        res_sign;
    logic [7:0]  res_exp;
    logic [27:0] res_mantis;
    logic        res_zero;
    logic        res_ovf;
    logic        res_uflow;

    fp_addsub_seq #(.NORM_STEP(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .a_sign(a_sign), .a_exp(a_exp), .a_mantis(a_mantis),
        .b_sign(b_sign), .b_exp(b_exp), .b_mantis(b_mantis),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_sign(res_sign), .res_exp(res_exp), .res_mantis(res_mantis),
        .res_zero(res_zero), .res_ovf(res_ovf), .res_uflow(res_uflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic        as;
        logic [7:0]  ae;
        logic [27:0] am;
        logic        bs;
        logic [7:0]  be;
        logic [27:0] bm;
        logic        es;
        logic [7:0]  ee;
        logic [27:0] em;
        logic        ez;
        logic        eo;
        logic        eu;
        int          lat;
    } vec_t;

    vec_t vecs[14];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Driver tasks
    task automatic drive_op(input vec_t v);
        @(negedge clk);
        op_sub = v.sub;
        a_sign = v.as; a_exp = v.ae; a_mantis = v.am;
        b_sign = v.bs; b_exp = v.be; b_mantis = v.bm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_res(input vec_t v, input string tag);
        chk({tag, "_sign"},   {31'd0, res_sign}, {31'd0, v.es});
        chk({tag, "_exp"},    {24'd0, res_exp},  {24'd0, v.ee});
        chk({tag, "_mantis"}, {4'd0, res_mantis}, {4'd0, v.em});
        chk({tag, "_flags"},  {29'd0, res_zero, res_ovf, res_uflow},
            {29'd0, v.ez, v.eo, v.eu});
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_handoff"}, {28'd0, out_valid, in_ready, res_zero | res_ovf, res_uflow},
            {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int edges;
        drive_op(v);
        wait_done(edges);
        chk({tag, "_latency"}, edges, v.lat);
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        check_res(v, tag);
        release_out(tag);
    endtask

    function automatic vec_t mk(logic sub, logic as, logic [7:0] ae, logic [27:0] am,
                                logic bs, logic [7:0] be, logic [27:0] bm,
                                logic es, logic [7:0] ee, logic [27:0] em,
                                logic ez, logic eo, logic eu, int lat);
        vec_t v;
        v.sub = sub; v.as = as; v.ae = ae; v.am = am;
        v.bs = bs; v.be = be; v.bm = bm;
        v.es = es; v.ee = ee; v.em = em;
        v.ez = ez; v.eo = eo; v.eu = eu; v.lat = lat;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   edges;
        vecs[0]  = mk(0, 0, 130, 28'h4000000, 0, 128, 28'h4000000, 0, 130, 28'h5000000, 0, 0, 0, 3);
        vecs[1]  = mk(0, 0, 130, 28'h4000000, 0, 130, 28'h4000000, 0, 131, 28'h4000000, 0, 0, 0, 3);
        vecs[2]  = mk(1, 0, 130, 28'h4000000, 0, 130, 28'h3FFFFF8, 0, 107, 28'h4000000, 0, 0, 0, 5);
        vecs[3]  = mk(1, 1,  77, 28'h5000000, 1,  77, 28'h5000000, 0,   0, 28'h0000000, 1, 0, 0, 3);
        vecs[4]  = mk(1, 0,   5, 28'h4000000, 0,   5, 28'h3FFFFF8, 0,   0, 28'h0000000, 0, 0, 1, 3);
        vecs[5]  = mk(0, 0, 254, 28'h4000000, 0, 254, 28'h4000000, 0, 255, 28'h0000000, 0, 1, 0, 3);
        vecs[6]  = mk(0, 0, 100, 28'h4000000, 1, 200, 28'h4000000, 1, 200, 28'h4000000, 0, 0, 0, 3);
        vecs[7]  = mk(1, 0, 128, 28'h4000000, 0, 130, 28'h4000000, 1, 129, 28'h6000000, 0, 0, 0, 3);
        vecs[8]  = mk(0, 1, 140, 28'h6000000, 0, 140, 28'h2000000, 1, 140, 28'h4000000, 0, 0, 0, 3);
        vecs[9]  = mk(0, 0, 157, 28'h4000000, 0, 131, 28'h4000000, 0, 157, 28'h4000001, 0, 0, 0, 3);
        vecs[10] = mk(1, 0, 100, 28'h4000000, 0, 100, 28'h3FC0000, 0,  92, 28'h4000000, 0, 0, 0, 3);
        vecs[11] = mk(1, 0, 100, 28'h4000000, 0, 100, 28'h3FE0000, 0,  91, 28'h4000000, 0, 0, 0, 4);
        vecs[12] = mk(1, 0,   8, 28'h4000000, 0,   8, 28'h3FC0000, 0,   0, 28'h0000000, 0, 0, 1, 3);
        vecs[13] = mk(1, 0,   9, 28'h4000000, 0,   9, 28'h3FC0000, 0,   1, 28'h4000000, 0, 0, 0, 3);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
        a_sign = 1'b0; a_exp = '0; a_mantis = '0;
        b_sign = 1'b0; b_exp = '0; b_mantis = '0;
        #17;
        chk("reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("reset_res", {res_sign, res_exp, res_mantis, res_zero, res_ovf, res_uflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: result held for 5 cycles while new operands are offered
        drive_op(vecs[0]);
        wait_done(edges);
        chk("hold_latency", edges, 3);
        @(negedge clk);
        v = vecs[5];
        op_sub = v.sub; a_sign = 1'b1; a_exp = v.ae; a_mantis = v.am;
        b_sign = v.bs; b_exp = v.be; b_mantis = v.bm;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_hs", c), {30'd0, out_valid, in_ready}, 32'd2);
            check_res(vecs[0], $sformatf("hold%0d", c));
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("hold");

        // Reset in the middle of a multi-cycle normalization
        drive_op(vecs[2]);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy", {30'd0, out_valid, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("midreset_res", {res_sign, res_exp, res_mantis, res_zero, res_ovf, res_uflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[2], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
